// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master core between NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GW          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_wr,
  input  logic [NUM_REQ*7-1:0] req_dev,
  input  logic [NUM_REQ*8-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 m_start,
  output logic                 m_wr,
  output logic [6:0]           m_dev,
  output logic [7:0]           m_addr,
  output logic [7:0]           m_wdata,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic [7:0]           m_rdata,
  input  logic                 m_ack_err,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GW != $clog2(NUM_REQ) || TIMEOUT_CYC < 2) begin : g_cfg_err
    $error("i2c_bus_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 m_wr_q, m_wr_d;
  logic [6:0]           m_dev_q, m_dev_d;
  logic [7:0]           m_addr_q, m_addr_d;
  logic [7:0]           m_wdata_q, m_wdata_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;

  logic [GW-1:0]        win_id;
  logic [GW-1:0]        cand;
  int                   sum;
  logic                 sel_wr;
  logic [6:0]           sel_dev;
  logic [7:0]           sel_addr;
  logic [7:0]           sel_wdata;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC) > 20) ? $clog2(TIMEOUT_CYC) : 20;
  logic [TW-1:0]        cnt_q, cnt_d;
`endif

  // Round-robin winner: descending scan so the candidate nearest ptr is assigned last.
  always_comb begin
    win_id = {GW{1'b0}};
    cand   = {GW{1'b0}};
    sum    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum    = int'(ptr_q) + i;
      cand   = GW'((sum >= NUM_REQ) ? (sum - NUM_REQ) : sum);
      win_id = req_valid[cand] ? cand : win_id;
    end
  end

  // Mux the winning requester's command fields.
  always_comb begin
    sel_wr    = 1'b0;
    sel_dev   = 7'h00;
    sel_addr  = 8'h00;
    sel_wdata = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_wr    = (win_id == GW'(i)) ? req_wr[i]          : sel_wr;
      sel_dev   = (win_id == GW'(i)) ? req_dev[7*i +: 7]  : sel_dev;
      sel_addr  = (win_id == GW'(i)) ? req_addr[8*i +: 8] : sel_addr;
      sel_wdata = (win_id == GW'(i)) ? req_wdata[8*i +: 8] : sel_wdata;
    end
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    m_wr_d      = m_wr_q;
    m_dev_d     = m_dev_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    req_ready_d = {NUM_REQ{1'b0}};
    rsp_valid_d = {NUM_REQ{1'b0}};
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d     = S_GRANT;
          grant_d     = win_id;
          m_wr_d      = sel_wr;
          m_dev_d     = sel_dev;
          m_addr_d    = sel_addr;
          m_wdata_d   = sel_wdata;
          req_ready_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: state_d = S_ISSUE;
      S_ISSUE: begin
        if (!m_busy) begin
          state_d = S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_d   = {TW{1'b0}};
`endif
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        // A completion in the same cycle as the timeout wins.
        if (m_done) begin
          state_d     = S_RESP;
          rsp_data_d  = m_wr_q ? 8'h00 : m_rdata;
          rsp_err_d   = m_ack_err;
          rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
`ifdef I2C_ARB_TIMEOUT_EN
        end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d     = S_RESP;
          rsp_data_d  = 8'hFF;
          rsp_err_d   = 1'b1;
          rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
        end else begin
          cnt_d = cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end
`else
        end else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
        ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? {GW{1'b0}}
                                                 : grant_q + {{(GW-1){1'b0}}, 1'b1};
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= {GW{1'b0}};
      grant_q     <= {GW{1'b0}};
      m_wr_q      <= 1'b0;
      m_dev_q     <= 7'h00;
      m_addr_q    <= 8'h00;
      m_wdata_q   <= 8'h00;
      req_ready_q <= {NUM_REQ{1'b0}};
      rsp_valid_q <= {NUM_REQ{1'b0}};
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q       <= {TW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      m_wr_q      <= m_wr_d;
      m_dev_q     <= m_dev_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // m_start must react to m_busy in the same ISSUE cycle to meet the two-cycle latency.
  assign m_start   = (state_q == S_ISSUE) && !m_busy;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign m_wr      = m_wr_q;
  assign m_dev     = m_dev_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule
